aib_link_bringup_seq: RTL and testbench
=======================================

// Module: aib_link_bringup_seq
// PURPOSE
//  Link bring-up sequencer upstream of the AIB-AXI bridge follower, in the clk_wr domain.
//  Drives the bridge's per-channel PHY control inputs:
//    ns_adapter_rstn, ns_mac_rdy and the four dcc/dll lock requests.
//  Waits for far-side device detect, transfer enable and RX alignment,
//  then raises tx_online/rx_online for the AXI-MM follower.
//  Reports a timeout or link-loss error and recovers via software re-enable.
// PARAMETERS
//  NBR_CHNLS     24        number of AIB channels (width of per-channel vectors)
//  CHNL_MASK     24'h1     channels brought up; unmasked channels held in reset
//  RST_HOLD_CYC  16        clk_wr cycles ns_adapter_rstn held low after detect (>=1)
//  TMO_W         20        width of timeout counter
//  TIMEOUT_CYC   20'd65535 cycles allowed in each of LOCK and ALIGN (>=1, < 2**TMO_W)
// PORTS
//  clk_wr                  in   1          bridge MAC clock
//  rst_wr_n                in   1          async active-low reset
//  enable                  in   1          software bring-up request, clk_wr domain
//  m_device_detect         in   1          AUX device detect (async)
//  ms_tx_transfer_en       in   NBR_CHNLS  PHY leader transfer enable (async)
//  sl_tx_transfer_en       in   NBR_CHNLS  PHY follower transfer enable (async)
//  m_rx_align_done         in   NBR_CHNLS  PHY RX word alignment done (async)
//  ns_adapter_rstn         out  NBR_CHNLS  adapter reset to PHY, active low
//  ns_mac_rdy              out  NBR_CHNLS  near-side MAC ready to PHY
//  ms_rx_dcc_dll_lock_req  out  NBR_CHNLS  lock request
//  ms_tx_dcc_dll_lock_req  out  NBR_CHNLS  lock request
//  sl_rx_dcc_dll_lock_req  out  NBR_CHNLS  lock request
//  sl_tx_dcc_dll_lock_req  out  NBR_CHNLS  lock request
//  link_online             out  1          drives tx_online/rx_online of AXI follower
//  link_err                out  1          error flag, valid while in ERROR
//  err_code                out  2          01 lock timeout, 10 align timeout, 11 link lost
//  state                   out  3          current FSM state encoding (debug)
// BEHAVIOUR
//  Input synchronisation
//   - All async inputs pass through 2-flop synchronisers; 2-cycle latency counted in all timing below.
//   - "xfer_ok" = &(ms_sync & sl_sync | ~CHNL_MASK); "align_ok" = &(align_sync | ~CHNL_MASK).
//  Reset and outputs
//   - Reset: state=IDLE, cnt=0; every output 0, including ns_adapter_rstn (adapter held in reset).
//   - All outputs are registered and change on the cycle after the state change.
//   - Per-channel outputs are always ANDed with CHNL_MASK; unmasked bits stay 0.
//  States (encoding)
//   IDLE(0)   : outputs 0. enable=1 -> DETECT.
//   DETECT(1) : waits for det_sync=1 -> RST_HOLD. No timeout.
//   RST_HOLD(2): ns_adapter_rstn=0. After exactly RST_HOLD_CYC cycles (cnt==RST_HOLD_CYC-1) -> LOCK.
//   LOCK(3)   : ns_adapter_rstn=MASK, ns_mac_rdy=MASK, all four lock_req=MASK.
//               xfer_ok -> ALIGN; cnt==TIMEOUT_CYC-1 -> ERROR, err_code=01.
//   ALIGN(4)  : LOCK outputs held. align_ok -> UP; timeout -> ERROR, err_code=10.
//   UP(5)     : LOCK outputs held; link_online=1.
//               Loss of xfer_ok, align_ok or det_sync -> ERROR, err_code=11.
//   ERROR(7)  : all per-channel outputs 0, link_online=0, link_err=1, err_code held.
//               enable=0 -> IDLE, which clears link_err and err_code.
//  Counter and priorities
//   - cnt clears on every state entry and saturates; it is used only in RST_HOLD, LOCK and ALIGN.
//   - Priority: enable=0 in any non-ERROR state -> IDLE next cycle, with no error; outputs drop to 0.
//   - Success beats timeout when both occur in the same cycle.
//   - enable=0 together with link loss in UP -> IDLE; link_err stays 0.
//   - enable held 1 in ERROR: the FSM stays in ERROR. There is no auto-retry.
//   - Async reset mid-sequence returns every output to its reset value immediately.
// TESTING
//  1 Nominal path, CHNL_MASK=1, RST_HOLD_CYC=16:
//    enable=1, detect=1, transfer_en ch0 raised 100 cycles after LOCK, align 50 cycles later
//    -> ns_adapter_rstn[0] rises exactly 16 cycles after RST_HOLD entry; link_online=1; bits[23:1] stay 0.
//  2 LOCK timeout, TIMEOUT_CYC=1000, transfer_en never raised
//    -> ERROR after 1000 cycles in LOCK, link_err=1, err_code=01, all outputs 0.
//    Then enable=0 -> IDLE, link_err=0.
//  3 Link loss: in UP, drop sl_tx_transfer_en[0] for 1 cycle
//    -> ERROR with err_code=11 within 3 cycles; link_online=0.
//  4 Multi-channel CHNL_MASK=24'h00000F, ch3 align late:
//    -> stays in ALIGN until ch3 align_done; ch4..23 transitions ignored.
//  5 Collisions: align_done arrives on the timeout cycle -> UP, not ERROR.
//    enable=0 coincident with link loss -> IDLE, link_err=0.
//  6 rst_wr_n pulsed low during ALIGN -> all outputs 0 immediately; full sequence repeats after release.

Source files
------------

// File: rtl/aib_link_bringup_seq.sv
// Link bring-up sequencer for the AIB-AXI bridge follower (clk_wr domain).
// Sequences adapter reset, DCC/DLL lock and RX alignment, then raises link_online.
module aib_link_bringup_seq #(
  parameter int                     NBR_CHNLS    = 24,
  parameter logic [NBR_CHNLS-1:0]   CHNL_MASK    = 24'h1,
  parameter int                     RST_HOLD_CYC = 16,
  parameter int                     TMO_W        = 20,
  parameter logic [TMO_W-1:0]       TIMEOUT_CYC  = 20'd65535
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr_n,
  input  logic                 enable,
  input  logic                 m_device_detect,
  input  logic [NBR_CHNLS-1:0] ms_tx_transfer_en,
  input  logic [NBR_CHNLS-1:0] sl_tx_transfer_en,
  input  logic [NBR_CHNLS-1:0] m_rx_align_done,
  output logic [NBR_CHNLS-1:0] ns_adapter_rstn,
  output logic [NBR_CHNLS-1:0] ns_mac_rdy,
  output logic [NBR_CHNLS-1:0] ms_rx_dcc_dll_lock_req,
  output logic [NBR_CHNLS-1:0] ms_tx_dcc_dll_lock_req,
  output logic [NBR_CHNLS-1:0] sl_rx_dcc_dll_lock_req,
  output logic [NBR_CHNLS-1:0] sl_tx_dcc_dll_lock_req,
  output logic                 link_online,
  output logic                 link_err,
  output logic [1:0]           err_code,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DETECT   = 3'd1,
    ST_RST_HOLD = 3'd2,
    ST_LOCK     = 3'd3,
    ST_ALIGN    = 3'd4,
    ST_UP       = 3'd5,
    ST_ERROR    = 3'd7
  } st_e;

  localparam logic [TMO_W-1:0] RST_LAST = TMO_W'(RST_HOLD_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT_CYC - TMO_W'(1);

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (&v) ? v : v + TMO_W'(1);
  endfunction

  logic                 det_p0, det_p1;
  logic [NBR_CHNLS-1:0] ms_p0, ms_p1, sl_p0, sl_p1, align_p0, align_p1;
  logic                 xfer_ok, align_ok;

  st_e                  cur_st, nxt;
  logic [TMO_W-1:0]     cnt;
  logic [1:0]           err_q, err_nxt;
  logic                 link_act;
  logic [NBR_CHNLS-1:0] chn_on;

  // stage p0/p1: two-flop synchronisers for every asynchronous PHY/AUX input
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      det_p0   <= 1'b0;
      det_p1   <= 1'b0;
      ms_p0    <= '0;
      ms_p1    <= '0;
      sl_p0    <= '0;
      sl_p1    <= '0;
      align_p0 <= '0;
      align_p1 <= '0;
    end else begin
      det_p0   <= m_device_detect;
      det_p1   <= det_p0;
      ms_p0    <= ms_tx_transfer_en;
      ms_p1    <= ms_p0;
      sl_p0    <= sl_tx_transfer_en;
      sl_p1    <= sl_p0;
      align_p0 <= m_rx_align_done;
      align_p1 <= align_p0;
    end
  end

  assign xfer_ok  = &((ms_p1 & sl_p1) | ~CHNL_MASK);
  assign align_ok = &(align_p1 | ~CHNL_MASK);

  always_comb begin
    nxt     = cur_st;
    err_nxt = err_q;
    if (cur_st != ST_ERROR && !enable) begin
      nxt = ST_IDLE;
    end else begin
      case (cur_st)
        ST_IDLE:     nxt = ST_DETECT;
        ST_DETECT:   if (det_p1) nxt = ST_RST_HOLD;
        ST_RST_HOLD: if (cnt == RST_LAST) nxt = ST_LOCK;
        // success is tested first so it wins a same-cycle timeout
        ST_LOCK: begin
          if (xfer_ok) begin
            nxt = ST_ALIGN;
          end else if (cnt == TMO_LAST) begin
            nxt     = ST_ERROR;
            err_nxt = 2'b01;
          end
        end
        ST_ALIGN: begin
          if (align_ok) begin
            nxt = ST_UP;
          end else if (cnt == TMO_LAST) begin
            nxt     = ST_ERROR;
            err_nxt = 2'b10;
          end
        end
        ST_UP: begin
          if (!(xfer_ok && align_ok && det_p1)) begin
            nxt     = ST_ERROR;
            err_nxt = 2'b11;
          end
        end
        ST_ERROR: if (!enable) nxt = ST_IDLE;
        default:  nxt = ST_IDLE;
      endcase
    end
    if (nxt == ST_IDLE) err_nxt = 2'b00;
  end

  assign link_act = (cur_st == ST_LOCK) || (cur_st == ST_ALIGN) || (cur_st == ST_UP);
  assign chn_on   = link_act ? CHNL_MASK : '0;

  // FSM state plus output registers decoded from the state held before the edge
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      cur_st                 <= ST_IDLE;
      cnt                    <= '0;
      err_q                  <= 2'b00;
      state                  <= 3'd0;
      ns_adapter_rstn        <= '0;
      ns_mac_rdy             <= '0;
      ms_rx_dcc_dll_lock_req <= '0;
      ms_tx_dcc_dll_lock_req <= '0;
      sl_rx_dcc_dll_lock_req <= '0;
      sl_tx_dcc_dll_lock_req <= '0;
      link_online            <= 1'b0;
      link_err               <= 1'b0;
      err_code               <= 2'b00;
    end else begin
      cur_st                 <= nxt;
      cnt                    <= (nxt != cur_st) ? '0 : sat_inc(cnt);
      err_q                  <= err_nxt;
      state                  <= cur_st;
      ns_adapter_rstn        <= chn_on;
      ns_mac_rdy             <= chn_on;
      ms_rx_dcc_dll_lock_req <= chn_on;
      ms_tx_dcc_dll_lock_req <= chn_on;
      sl_rx_dcc_dll_lock_req <= chn_on;
      sl_tx_dcc_dll_lock_req <= chn_on;
      link_online            <= (cur_st == ST_UP);
      link_err               <= (cur_st == ST_ERROR);
      err_code               <= (cur_st == ST_ERROR) ? err_q : 2'b00;
    end
  end

endmodule

// File: tb/tb_aib_link_bringup_seq.sv
// Randomised bench for aib_link_bringup_seq against a queue-based reference model,
// plus directed checks of hold time, timeouts, link loss, collisions and async reset.
module tb_aib_link_bringup_seq;

  localparam int             N    = 24;
  localparam logic [N-1:0]   MASK = 24'h00000F;
  localparam int             RH   = 16;
  localparam int             TMO  = 1000;

  logic         clk_wr = 1'b0;
  logic         rst_wr_n;
  logic         enable;
  logic         m_device_detect;
  logic [N-1:0] ms_tx_transfer_en, sl_tx_transfer_en, m_rx_align_done;
  logic [N-1:0] ns_adapter_rstn, ns_mac_rdy;
  logic [N-1:0] ms_rx_dcc_dll_lock_req, ms_tx_dcc_dll_lock_req;
  logic [N-1:0] sl_rx_dcc_dll_lock_req, sl_tx_dcc_dll_lock_req;
  logic         link_online, link_err;
  logic [1:0]   err_code;
  logic [2:0]   state;

  aib_link_bringup_seq #(
    .NBR_CHNLS(N), .CHNL_MASK(MASK), .RST_HOLD_CYC(RH), .TMO_W(20), .TIMEOUT_CYC(20'd1000)
  ) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .enable(enable), .m_device_detect(m_device_detect),
    .ms_tx_transfer_en(ms_tx_transfer_en), .sl_tx_transfer_en(sl_tx_transfer_en),
    .m_rx_align_done(m_rx_align_done), .ns_adapter_rstn(ns_adapter_rstn), .ns_mac_rdy(ns_mac_rdy),
    .ms_rx_dcc_dll_lock_req(ms_rx_dcc_dll_lock_req), .ms_tx_dcc_dll_lock_req(ms_tx_dcc_dll_lock_req),
    .sl_rx_dcc_dll_lock_req(sl_rx_dcc_dll_lock_req), .sl_tx_dcc_dll_lock_req(sl_tx_dcc_dll_lock_req),
    .link_online(link_online), .link_err(link_err), .err_code(err_code), .state(state)
  );

  always #5 clk_wr = ~clk_wr;

  int n_chk  = 0;
  int n_pass = 0;
  int k;

  // reference model: phase number, cycles spent in phase, latched error cause
  int           mst, dwell;
  logic [1:0]   merr;
  logic         det_h[$];
  logic [N-1:0] ms_h[$], sl_h[$], al_h[$];
  logic [2:0]   e_state;
  logic [N-1:0] e_chn;
  logic         e_online, e_lerr;
  logic [1:0]   e_code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic reset_model();
    mst = 0; dwell = 0; merr = 2'b00;
    e_state = 3'd0; e_chn = '0; e_online = 1'b0; e_lerr = 1'b0; e_code = 2'b00;
    det_h = '{1'b0, 1'b0};
    ms_h  = '{24'h0, 24'h0};
    sl_h  = '{24'h0, 24'h0};
    al_h  = '{24'h0, 24'h0};
  endtask

  // one clock edge of the spec: outputs show the phase held before the edge,
  // decisions use inputs as seen two edges earlier
  task automatic model_tick();
    logic         sdet, xfer, alok;
    logic [N-1:0] sms, ssl, sal;
    int           nst;
    e_state  = 3'(mst);
    e_chn    = (mst >= 3 && mst <= 5) ? MASK : '0;
    e_online = (mst == 5);
    e_lerr   = (mst == 7);
    e_code   = (mst == 7) ? merr : 2'b00;
    det_h.push_front(m_device_detect);
    ms_h.push_front(ms_tx_transfer_en);
    sl_h.push_front(sl_tx_transfer_en);
    al_h.push_front(m_rx_align_done);
    sdet = det_h[2]; sms = ms_h[2]; ssl = sl_h[2]; sal = al_h[2];
    void'(det_h.pop_back()); void'(ms_h.pop_back());
    void'(sl_h.pop_back());  void'(al_h.pop_back());
    xfer = ((sms & ssl & MASK) == MASK);
    alok = ((sal & MASK) == MASK);
    nst = mst;
    if (mst != 7 && !enable) nst = 0;
    else if (mst == 0) nst = 1;
    else if (mst == 1 && sdet) nst = 2;
    else if (mst == 2 && dwell == RH - 1) nst = 3;
    else if (mst == 3 && xfer) nst = 4;
    else if (mst == 3 && dwell == TMO - 1) begin nst = 7; merr = 2'd1; end
    else if (mst == 4 && alok) nst = 5;
    else if (mst == 4 && dwell == TMO - 1) begin nst = 7; merr = 2'd2; end
    else if (mst == 5 && !(xfer && alok && sdet)) begin nst = 7; merr = 2'd3; end
    else if (mst == 7 && !enable) nst = 0;
    if (nst == 0) merr = 2'b00;
    dwell = (nst != mst) ? 0 : dwell + 1;
    mst = nst;
  endtask

  task automatic cmp_all();
    check("state",       32'(state), 32'(e_state));
    check("adapter_rstn", 32'(ns_adapter_rstn), 32'(e_chn));
    check("mac_rdy",     32'(ns_mac_rdy), 32'(e_chn));
    check("ms_rx_lock",  32'(ms_rx_dcc_dll_lock_req), 32'(e_chn));
    check("ms_tx_lock",  32'(ms_tx_dcc_dll_lock_req), 32'(e_chn));
    check("sl_rx_lock",  32'(sl_rx_dcc_dll_lock_req), 32'(e_chn));
    check("sl_tx_lock",  32'(sl_tx_dcc_dll_lock_req), 32'(e_chn));
    check("link_online", 32'(link_online), 32'(e_online));
    check("link_err",    32'(link_err), 32'(e_lerr));
    check("err_code",    32'(err_code), 32'(e_code));
  endtask

  task automatic step();
    @(posedge clk_wr);
    #1;
    model_tick();
    cmp_all();
  endtask

  function automatic logic [N-1:0] noisy(input logic [N-1:0] v);
    return (v & MASK) | (24'($urandom) & ~MASK);
  endfunction

  // advance while toggling the channels outside the mask
  task automatic run(input int n);
    repeat (n) begin
      step();
      ms_tx_transfer_en = noisy(ms_tx_transfer_en);
      sl_tx_transfer_en = noisy(sl_tx_transfer_en);
      m_rx_align_done   = noisy(m_rx_align_done);
    end
  endtask

  task automatic wait_st(input logic [2:0] code, input int budget, input string tag);
    int n = 0;
    while (state !== code && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(state), 32'(code));
  endtask

  task automatic random_phase(input int n);
    int idx;
    repeat (n) begin
      run(1);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 69) == 0) m_device_detect = ~m_device_detect;
      idx = $urandom_range(0, 4);
      if ($urandom_range(0, 24) == 0) ms_tx_transfer_en[idx] = ~ms_tx_transfer_en[idx];
      idx = $urandom_range(0, 4);
      if ($urandom_range(0, 24) == 0) sl_tx_transfer_en[idx] = ~sl_tx_transfer_en[idx];
      idx = $urandom_range(0, 4);
      if ($urandom_range(0, 19) == 0) m_rx_align_done[idx] = ~m_rx_align_done[idx];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_wr_n = 1'b0; enable = 1'b0; m_device_detect = 1'b0;
    ms_tx_transfer_en = '0; sl_tx_transfer_en = '0; m_rx_align_done = '0;
    reset_model();
    #23;
    cmp_all();
    rst_wr_n = 1'b1;
    run(3);

    // nominal bring-up and adapter reset hold time
    enable = 1'b1; m_device_detect = 1'b1;
    wait_st(3'd2, 50, "reach_rst_hold");
    k = 0;
    while (ns_adapter_rstn[0] !== 1'b1 && k < 100) begin step(); k++; end
    check("rstn_hold_cycles", 32'(k), 32'(RH));
    wait_st(3'd3, 10, "reach_lock");
    run(100);
    ms_tx_transfer_en = noisy(MASK); sl_tx_transfer_en = noisy(MASK);
    run(50);
    m_rx_align_done = noisy(MASK);
    wait_st(3'd5, 20, "reach_up");
    check("up_online", 32'(link_online), 32'd1);
    check("up_unmasked_zero", 32'(ns_adapter_rstn & ~MASK), 32'd0);

    // one-cycle link loss
    sl_tx_transfer_en[0] = 1'b0;
    step();
    sl_tx_transfer_en[0] = 1'b1;
    run(3);
    check("loss_state", 32'(state), 32'd7);
    check("loss_code", 32'(err_code), 32'd3);
    check("loss_online", 32'(link_online), 32'd0);
    run(20);
    check("error_sticky", 32'(state), 32'd7);
    enable = 1'b0;
    run(2);
    check("clear_state", 32'(state), 32'd0);
    check("clear_err", 32'(link_err), 32'd0);

    // lock timeout
    ms_tx_transfer_en = noisy('0); sl_tx_transfer_en = noisy('0); m_rx_align_done = noisy('0);
    enable = 1'b1;
    wait_st(3'd3, 100, "tmo_reach_lock");
    k = 0;
    while (state !== 3'd7 && k < 1100) begin step(); k++; end
    check("lock_tmo_cycles", 32'(k), 32'(TMO));
    check("lock_tmo_code", 32'(err_code), 32'd1);
    check("lock_tmo_err", 32'(link_err), 32'd1);
    check("lock_tmo_rstn", 32'(ns_adapter_rstn), 32'd0);
    enable = 1'b0;
    run(2);
    check("tmo_clear", 32'(link_err), 32'd0);

    // multi-channel, ch3 aligns late
    ms_tx_transfer_en = noisy(MASK); sl_tx_transfer_en = noisy(MASK);
    m_rx_align_done = noisy(24'h000007);
    enable = 1'b1;
    wait_st(3'd4, 100, "mc_reach_align");
    run(200);
    check("mc_hold_align", 32'(state), 32'd4);
    m_rx_align_done = noisy(MASK);
    wait_st(3'd5, 20, "mc_reach_up");

    // align arriving on the timeout edge wins
    enable = 1'b0; m_rx_align_done = noisy('0);
    run(3);
    enable = 1'b1;
    wait_st(3'd4, 100, "col_reach_align");
    run(996);
    m_rx_align_done = noisy(MASK);
    run(8);
    check("col_align_wins", 32'(state), 32'd5);

    // one cycle later it is an align timeout
    enable = 1'b0; m_rx_align_done = noisy('0);
    run(3);
    enable = 1'b1;
    wait_st(3'd4, 100, "late_reach_align");
    run(997);
    m_rx_align_done = noisy(MASK);
    run(8);
    check("late_state", 32'(state), 32'd7);
    check("late_code", 32'(err_code), 32'd2);

    // disable coincident with link loss
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    wait_st(3'd5, 100, "dis_reach_up");
    sl_tx_transfer_en[0] = 1'b0;
    run(2);
    enable = 1'b0;
    run(3);
    check("dis_state", 32'(state), 32'd0);
    check("dis_err", 32'(link_err), 32'd0);
    sl_tx_transfer_en[0] = 1'b1;

    // async reset during ALIGN
    m_rx_align_done = noisy('0);
    enable = 1'b1;
    wait_st(3'd4, 100, "rst_reach_align");
    run(10);
    #2 rst_wr_n = 1'b0;
    #1;
    check("rst_rstn", 32'(ns_adapter_rstn), 32'd0);
    check("rst_lock", 32'(ms_tx_dcc_dll_lock_req | sl_rx_dcc_dll_lock_req), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_flags", 32'({link_online, link_err, err_code}), 32'd0);
    reset_model();
    #3 rst_wr_n = 1'b1;
    m_rx_align_done = noisy(MASK);
    wait_st(3'd5, 200, "rst_resequence_up");

    random_phase(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
